// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-SRAM responder slice.
// Holds the interface widths, the lane width of the byte banks, the
// stall-request encoding used by the pipeline stall bus, and the
// responder state type.
package data_sram_responder_pkg;

  localparam int DSRAM_WORD_WD  = 32;
  localparam int DSRAM_WEN_WD   = 4;
  localparam int DSRAM_WAIT_WD  = 4;
  localparam int DSRAM_LANE_WD  = 8;
  localparam int DSRAM_WAIT_MAX = 15;

  // Stall-bus encoding: Stop holds the pipeline, NoStop lets it advance.
  localparam logic STALL_STOP   = 1'b1;
  localparam logic STALL_NOSTOP = 1'b0;

  typedef enum logic {
    DSRAM_IDLE = 1'b0,
    DSRAM_BUSY = 1'b1
  } dsram_state_e;

  // Any set byte enable turns the access into a write; all-zero is a read.
  function automatic logic dsram_is_write(input logic [DSRAM_WEN_WD-1:0] wen);
    return |wen;
  endfunction

endpackage

// File: rtl/dsram_byte_bank.sv
// One byte lane of the data SRAM: 8-bit x 2**DEPTH_LOG2 synchronous bank.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset (clears dout only, not the array)
//   we    in  write this lane at addr
//   re    in  load dout from addr
//   addr  in  word index
//   din   in  lane write data
//   dout  out registered lane read data, held until the next read or reset
module dsram_byte_bank
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic [DEPTH_LOG2-1:0]    addr,
  input  logic [DSRAM_LANE_WD-1:0] din,
  output logic [DSRAM_LANE_WD-1:0] dout
);

  logic [DSRAM_LANE_WD-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Array write kept reset-free so the lane maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  // Output register doubles as the read-data hold register for this lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (re) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the data-SRAM interface: word-organised synchronous RAM
// with per-byte write enables, registered read data and optional wait states.
// Array contents come up undefined; images are loaded through ordinary writes.
// Ports:
//   clk              in   system clock
//   rst              in   synchronous active-high reset
//   data_sram_en     in   access request
//   data_sram_wen    in   byte write enables (all zero with en = read)
//   data_sram_addr   in   byte address, [DEPTH_LOG2+1:2] selects the word
//   data_sram_wdata  in   lane-aligned write data
//   data_sram_rdata  out  registered read word, changes only on a completed read
//   stallreq_mem     out  high while a wait-stated access is in progress
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_sram_en,
  input  logic [DSRAM_WEN_WD-1:0]  data_sram_wen,
  input  logic [DSRAM_WORD_WD-1:0] data_sram_addr,
  input  logic [DSRAM_WORD_WD-1:0] data_sram_wdata,
  output logic [DSRAM_WORD_WD-1:0] data_sram_rdata,
  output logic                     stallreq_mem
);

  localparam logic [DSRAM_WAIT_WD-1:0] WAIT_LOAD = DSRAM_WAIT_WD'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > DSRAM_WAIT_MAX) begin : g_bad_wait
    $error("data_sram_responder: WAIT_CYCLES must be within 0..15");
  end

  dsram_state_e             state;
  logic [DSRAM_WAIT_WD-1:0] wait_cnt;
  logic [DEPTH_LOG2-1:0]    word_idx;
  logic                     is_write;
  logic                     access_go;
  logic                     do_write;
  logic                     do_read;
  logic                     unused_addr_bits;

  // Upper address bits are dropped so the index wraps modulo the depth.
  assign word_idx         = data_sram_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{data_sram_addr[1:0], data_sram_addr[DSRAM_WORD_WD-1:DEPTH_LOG2+2]};
  assign is_write         = dsram_is_write(data_sram_wen);

  // Without wait states the request is served at the edge it is sampled;
  // otherwise only on the last BUSY edge, using the inputs the requester
  // has kept stable while stalled.
  assign access_go = (WAIT_CYCLES == 0) ? data_sram_en
                                        : (state == DSRAM_BUSY && wait_cnt == 4'd1);

  // Reset wins over an access sampled at the same edge, discarding it.
  assign do_write = access_go &  is_write & ~rst;
  assign do_read  = access_go & ~is_write & ~rst;

  // Wait-state FSM: accept in IDLE, count down in BUSY, requests seen while
  // BUSY are ignored rather than queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DSRAM_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        DSRAM_IDLE: begin
          if (data_sram_en && WAIT_CYCLES != 0) begin
            state    <= DSRAM_BUSY;
            wait_cnt <= WAIT_LOAD;
          end
        end
        DSRAM_BUSY: begin
          if (wait_cnt == 4'd1) begin
            state    <= DSRAM_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
          state    <= DSRAM_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign stallreq_mem = (state == DSRAM_BUSY) ? STALL_STOP : STALL_NOSTOP;

  // One bank per byte lane; the bank output registers form the rdata word.
  for (genvar lane = 0; lane < DSRAM_WEN_WD; lane++) begin : g_lane
    dsram_byte_bank #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (do_write & data_sram_wen[lane]),
      .re   (do_read),
      .addr (word_idx),
      .din  (data_sram_wdata[DSRAM_LANE_WD*lane +: DSRAM_LANE_WD]),
      .dout (data_sram_rdata[DSRAM_LANE_WD*lane +: DSRAM_LANE_WD])
    );
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized scoreboard bench for data_sram_responder. Two instances run side
// by side: index 0 is the single-cycle responder, index 1 has three wait states.
module tb_data_sram_responder;

  localparam int REGION = 40;

  typedef struct {
    int          k;
    int          cyc;
    bit          is_stall;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        en    [2];
  logic [3:0]  wen   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [31:0] model   [2][REGION];
  logic [31:0] last_rd [2];

  data_sram_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
    .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
    .data_sram_rdata(rdata[0]), .stallreq_mem(stall[0]));

  data_sram_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst[1]), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
    .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
    .data_sram_rdata(rdata[1]), .stallreq_mem(stall[1]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_exp(input int k, input int c, input bit is_stall, input logic [31:0] v);
    exp_t e;
    e.k = k; e.cyc = c; e.is_stall = is_stall; e.val = v;
    sb.push_back(e);
  endfunction

  // Monitor: pops every expectation due in the current cycle.
  task automatic checkOutput();
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      act = e.is_stall ? {31'b0, stall[e.k]} : rdata[e.k];
      if (e.cyc < cyc) begin
        failures++;
        $display("[TB] FAIL stale_expectation dut%0d due=%0d now=%0d", e.k, e.cyc, cyc);
      end else if (act !== e.val) begin
        failures++;
        $display("[TB] FAIL %s dut%0d cyc=%0d actual=%h required=%h",
                 e.is_stall ? "stallreq" : "rdata", e.k, cyc, act, e.val);
      end
    end
  endtask

  always @(negedge clk) checkOutput();

  task automatic drive(input int k, input logic e, input logic [3:0] w,
                       input logic [31:0] ad, input logic [31:0] wd);
    en[k] = e; wen[k] = w; addr[k] = ad; wdata[k] = wd;
  endtask

  // Applies the memory rules to the model at the moment of acceptance.
  task automatic model_access(input int k, input logic [3:0] w, input logic [31:0] ad,
                              input logic [31:0] wd);
    int idx;
    idx = int'((ad >> 2) & 32'hFFF);
    if (w == 4'b0000) begin
      last_rd[k] = model[k][idx];
    end else begin
      for (int b = 0; b < 4; b++)
        if (w[b]) model[k][idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic applyStimulus(input int k, input logic [3:0] w, input logic [31:0] ad,
                               input logic [31:0] wd, input bit noise);
    int          a;
    logic [31:0] prev;
    drive(k, 1'b1, w, ad, wd);
    @(posedge clk); #1;
    a = cyc;
    prev = last_rd[k];
    model_access(k, w, ad, wd);
    if (k == 0) begin
      push_exp(0, a, 1'b1, 32'd0);
      push_exp(0, a, 1'b0, last_rd[0]);
      en[0] = 1'b0;
    end else begin
      push_exp(1, a,     1'b1, 32'd1);
      push_exp(1, a,     1'b0, prev);
      push_exp(1, a + 1, 1'b1, 32'd1);
      push_exp(1, a + 1, 1'b0, prev);
      push_exp(1, a + 2, 1'b1, 32'd1);
      push_exp(1, a + 3, 1'b1, 32'd0);
      push_exp(1, a + 3, 1'b0, last_rd[1]);
      if (noise) begin
        for (int j = 0; j < 2; j++) begin
          drive(1, 1'($urandom()), 4'($urandom()),
                ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, REGION - 1)) << 2),
                $urandom());
          @(posedge clk); #1;
        end
        drive(1, 1'b1, w, ad, wd);
        @(posedge clk); #1;
      end else begin
        repeat (3) @(posedge clk);
        #1;
      end
      en[1] = 1'b0;
    end
  endtask

  task automatic idleCycle(input int k);
    en[k] = 1'b0;
    @(posedge clk); #1;
    push_exp(k, cyc, 1'b1, 32'd0);
    push_exp(k, cyc, 1'b0, last_rd[k]);
  endtask

  // Reset sampled together with a write request: the write must be dropped.
  task automatic resetWithRequest(input int k, input logic [31:0] ad, input logic [31:0] wd);
    drive(k, 1'b1, 4'b1111, ad, wd);
    rst[k] = 1'b1;
    @(posedge clk); #1;
    rst[k] = 1'b0;
    en[k]  = 1'b0;
    last_rd[k] = 32'd0;
    push_exp(k, cyc, 1'b1, 32'd0);
    push_exp(k, cyc, 1'b0, 32'd0);
  endtask

  // Reset raised during the second BUSY cycle of a wait-stated write.
  task automatic resetMidBusy(input logic [31:0] ad, input logic [31:0] wd);
    int a;
    drive(1, 1'b1, 4'b1111, ad, wd);
    @(posedge clk); #1;
    a = cyc;
    push_exp(1, a,     1'b1, 32'd1);
    push_exp(1, a + 1, 1'b1, 32'd1);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    en[1]  = 1'b0;
    last_rd[1] = 32'd0;
    push_exp(1, a + 2, 1'b1, 32'd0);
    push_exp(1, a + 2, 1'b0, 32'd0);
  endtask

  initial begin
    int          r;
    int          idx;
    logic [31:0] ad;
    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, 4'b0000, 32'd0, 32'd0);
      rst[k] = 1'b1;
      last_rd[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      push_exp(k, cyc, 1'b1, 32'd0);
      push_exp(k, cyc, 1'b0, 32'd0);
      rst[k] = 1'b0;
    end

    // Known contents for every word the bench touches.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < REGION; i++)
        applyStimulus(k, 4'b1111, 32'(i) << 2, $urandom(), 1'b0);

    // Single-cycle: write then read, partial-lane update, address wrap.
    applyStimulus(0, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 4'b0000, 32'h10, 32'h0, 1'b0);
    applyStimulus(0, 4'b1111, 32'h20, 32'h11223344, 1'b0);
    applyStimulus(0, 4'b0010, 32'h20, 32'h0000AA00, 1'b0);
    applyStimulus(0, 4'b0000, 32'h20, 32'h0, 1'b0);
    applyStimulus(0, 4'b1111, 32'h4000, 32'hCAFEF00D, 1'b0);
    applyStimulus(0, 4'b0000, 32'h0000, 32'h0, 1'b0);
    resetWithRequest(0, 32'h24, 32'h0BADF00D);
    applyStimulus(0, 4'b0000, 32'h24, 32'h0, 1'b0);

    // Wait-stated: read, busy-time noise, wrap, reset mid-access.
    applyStimulus(1, 4'b1111, 32'h40, 32'h55AA55AA, 1'b0);
    applyStimulus(1, 4'b0000, 32'h40, 32'h0, 1'b0);
    applyStimulus(1, 4'b0000, 32'h40, 32'h0, 1'b1);
    applyStimulus(1, 4'b1111, 32'h44, 32'h01020304, 1'b1);
    applyStimulus(1, 4'b1111, 32'h4000, 32'hCAFEF00D, 1'b0);
    applyStimulus(1, 4'b0000, 32'h0000, 32'h0, 1'b0);
    resetMidBusy(32'h80, 32'h12345678);
    applyStimulus(1, 4'b0000, 32'h80, 32'h0, 1'b0);

    // Random traffic; upper address bits randomised to exercise wrapping.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 150; n++) begin
        r   = $urandom_range(0, 9);
        idx = $urandom_range(0, REGION - 1);
        ad  = ($urandom() & 32'hFFFF_C000) | (32'(idx) << 2) | ($urandom() & 32'h3);
        if (r < 2)
          idleCycle(k);
        else if (r < 6)
          applyStimulus(k, 4'b0000, ad, $urandom(), (k == 1) && ($urandom_range(0, 1) == 1));
        else
          applyStimulus(k, 4'($urandom_range(1, 15)), ad, $urandom(),
                        (k == 1) && ($urandom_range(0, 1) == 1));
      end
    end

    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
